jaxis_byte_packer: RTL and testbench



---
 rtl/jaxis_byte_packer_pkg.sv | 13 +
 rtl/jaxis_byte_packer_if.sv | 26 ++
 rtl/jaxis_byte_packer_skid.sv | 48 ++++
 rtl/jaxis_byte_packer.sv | 146 ++++++++++++++
 tb/tb_jaxis_byte_packer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jaxis_byte_packer_pkg.sv
// Shared types for the JPEG output byte packer: capture FSM states and a tkeep popcount.
package jenc_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} jpack_state_t;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c += 5'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/jaxis_byte_packer_if.sv
// Encoder-beat input side and AXI-Stream output side of the byte packer.
interface jaxis_byte_packer_if #(
    parameter int IN_BYTES  = 4,
    parameter int OUT_BYTES = 4
);
    logic [8*IN_BYTES-1:0]          in_data;
    logic [$clog2(IN_BYTES+1)-1:0]  in_nbytes;
    logic                           in_valid;
    logic                           in_hold;
    logic                           in_tlast;
    logic [8*OUT_BYTES-1:0]         m_tdata;
    logic [OUT_BYTES-1:0]           m_tkeep;
    logic                           m_tvalid;
    logic                           m_tready;
    logic                           m_tlast;

    // slave: the packer; master: the encoder / sink pair driving it
    modport slave (
        input  in_data, in_nbytes, in_valid, in_tlast, m_tready,
        output in_hold, m_tdata, m_tkeep, m_tvalid, m_tlast
    );
    modport master (
        output in_data, in_nbytes, in_valid, in_tlast, m_tready,
        input  in_hold, m_tdata, m_tkeep, m_tvalid, m_tlast
    );
endinterface

// File: rtl/jaxis_byte_packer_skid.sv
// Two-entry valid/ready skid buffer with registered outputs and a synchronous clear.
module jaxis_skid #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    input  logic [DW-1:0] s_data_i,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic [DW-1:0] m_data_o
);
    logic [DW-1:0] out_q, sk_q;
    logic          out_v_q, sk_v_q;

    assign s_ready_o = ~sk_v_q;
    assign m_valid_o = out_v_q;
    assign m_data_o  = out_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            sk_q    <= '0;
            out_v_q <= 1'b0;
            sk_v_q  <= 1'b0;
        end else if (clr_i) begin
            out_v_q <= 1'b0;
            sk_v_q  <= 1'b0;
        end else if (!out_v_q || m_ready_i) begin
            // output slot frees up: drain the skid first, else pass straight through
            if (sk_v_q) begin
                out_q   <= sk_q;
                out_v_q <= 1'b1;
                sk_v_q  <= 1'b0;
            end else if (s_valid_i) begin
                out_q   <= s_data_i;
                out_v_q <= 1'b1;
            end else begin
                out_v_q <= 1'b0;
            end
        end else if (s_valid_i && !sk_v_q) begin
            sk_q   <= s_data_i;
            sk_v_q <= 1'b1;
        end
    end
endmodule

// File: rtl/jaxis_byte_packer.sv
// Packs variable-length encoder beats into OUT_BYTES-wide AXI-Stream words with
// tkeep/tlast, per-image byte count, byte cap and a start/abort/done capture FSM.
module jaxis_byte_packer
    import jenc_pkg::*;
#(
    parameter int IN_BYTES  = 4,
    parameter int OUT_BYTES = 4,
    parameter int LSB_FIRST = 1,
    parameter int SIZE_W    = 20,
    parameter int MAX_BYTES = 2**20-1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    jaxis_byte_packer_if.slave   bus,
    output logic [SIZE_W-1:0]    image_size,
    output logic                 done,
    output logic                 overflow
);
    localparam int ACC_BYTES = IN_BYTES + OUT_BYTES;
    localparam int CNT_W     = $clog2(ACC_BYTES + 1);
    localparam int NB_W      = $clog2(IN_BYTES + 1);
    localparam int CAP_W     = $clog2(MAX_BYTES + 1);
    localparam int DW        = 1 + OUT_BYTES + 8*OUT_BYTES;
    localparam logic [CNT_W-1:0] OUT_N    = CNT_W'(OUT_BYTES);
    localparam logic [SIZE_W:0]  SIZE_MAX = {1'b0, {SIZE_W{1'b1}}};

    jpack_state_t                state_q;
    logic [ACC_BYTES-1:0][7:0]   acc_q, acc_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d, nw, sh, avail;
    logic [CAP_W-1:0]            tot_q, room;
    logic [NB_W-1:0]             n_clip, n_keep;
    logic [SIZE_W-1:0]           size_q;
    logic [SIZE_W:0]             size_sum;
    logic                        last_sent_q, ovf_q;
    logic                        stream_st, flush_st, emit_want, push, push_last;
    logic                        hold, accept, ovf_hit, sk_ready, m_hs;
    logic [OUT_BYTES-1:0]        wkeep;
    logic [8*OUT_BYTES-1:0]      wdata;
    logic [DW-1:0]               sk_out;

    assign stream_st = (state_q == STREAM);
    assign flush_st  = (state_q == FLUSH);
    assign nw        = (cnt_q > OUT_N) ? OUT_N : cnt_q;
    assign push_last = flush_st && (cnt_q <= OUT_N);
    // while streaming one byte stays behind so the final word always carries data
    assign emit_want = (stream_st && cnt_q > OUT_N) || (flush_st && !last_sent_q);
    assign push      = emit_want && sk_ready;
    assign sh        = push ? nw : '0;
    assign avail     = cnt_q - sh;
    assign hold      = !(stream_st && avail <= OUT_N);
    assign accept    = bus.in_valid && !hold;
    assign bus.in_hold = hold;

    assign n_clip  = (bus.in_nbytes > NB_W'(IN_BYTES)) ? NB_W'(IN_BYTES) : bus.in_nbytes;
    assign room    = CAP_W'(MAX_BYTES) - tot_q;
    assign ovf_hit = 32'(n_clip) > 32'(room);
    assign n_keep  = ovf_hit ? NB_W'(room) : n_clip;

    // shift out the emitted word and append the accepted bytes in a single update
    always_comb begin
        acc_d = '0;
        for (int i = 0; i < ACC_BYTES; i++)
            if (i + int'(sh) < ACC_BYTES) acc_d[i] = acc_q[i + int'(sh)];
        cnt_d = avail;
        if (accept) begin
            for (int k = 0; k < IN_BYTES; k++)
                if (k < int'(n_keep) && int'(avail) + k < ACC_BYTES)
                    acc_d[int'(avail) + k] = bus.in_data[8*k +: 8];
            cnt_d = avail + CNT_W'(n_keep);
        end
    end

    always_comb begin
        wdata = '0;
        wkeep = '0;
        for (int b = 0; b < OUT_BYTES; b++)
            if (b < int'(nw)) begin
                wdata[8*((LSB_FIRST != 0) ? b : OUT_BYTES-1-b) +: 8] = acc_q[b];
                wkeep[(LSB_FIRST != 0) ? b : OUT_BYTES-1-b]          = 1'b1;
            end
    end

    jaxis_skid #(.DW(DW)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (abort),
        .s_valid_i (push),
        .s_ready_o (sk_ready),
        .s_data_i  ({push_last, wkeep, wdata}),
        .m_valid_o (bus.m_tvalid),
        .m_ready_i (bus.m_tready),
        .m_data_o  (sk_out)
    );

    assign {bus.m_tlast, bus.m_tkeep, bus.m_tdata} = sk_out;
    assign m_hs     = bus.m_tvalid && bus.m_tready;
    assign size_sum = {1'b0, size_q} + (SIZE_W+1)'(popcount16(16'(bus.m_tkeep)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            tot_q       <= '0;
            size_q      <= '0;
            last_sent_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (abort) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            last_sent_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (m_hs) size_q <= (size_sum > SIZE_MAX) ? SIZE_MAX[SIZE_W-1:0] : size_sum[SIZE_W-1:0];
            case (state_q)
                IDLE, DONE: if (start) begin
                    state_q <= STREAM;
                    size_q  <= '0;
                    ovf_q   <= 1'b0;
                    tot_q   <= '0;
                end
                STREAM: if (accept) begin
                    tot_q <= tot_q + CAP_W'(n_keep);
                    if (ovf_hit)      ovf_q   <= 1'b1;
                    if (bus.in_tlast) state_q <= FLUSH;
                end
                FLUSH: begin
                    if (push && push_last) last_sent_q <= 1'b1;
                    if (m_hs && bus.m_tlast) begin
                        state_q     <= DONE;
                        last_sent_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign image_size = size_q;
    assign done       = (state_q == DONE);
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_jaxis_byte_packer.sv
// Scoreboard bench: dut0 is LSB-first/uncapped, dut1 is MSB-first with a 16-byte cap.
module tb_jaxis_byte_packer;
    localparam int IB   = 4;
    localparam int OB   = 4;
    localparam int SW   = 20;
    localparam int CAP0 = 2**20-1;
    localparam int CAP1 = 16;

    typedef struct {
        logic [8*OB-1:0] data;
        logic [OB-1:0]   keep;
        logic            last;
    } word_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
    logic [SW-1:0] isz0, isz1;
    logic done0, done1, ovf0, ovf1;

    int tests = 0;
    int fails = 0;
    int hold_seen = 0;
    int rdy_pct [2] = '{100, 100};
    word_t q0[$];
    word_t q1[$];
    logic prev_stall [2] = '{1'b0, 1'b0};
    logic [8*OB+OB:0] prev_w [2];

    jaxis_byte_packer_if #(.IN_BYTES(IB), .OUT_BYTES(OB)) b0 ();
    jaxis_byte_packer_if #(.IN_BYTES(IB), .OUT_BYTES(OB)) b1 ();

    jaxis_byte_packer #(.IN_BYTES(IB), .OUT_BYTES(OB), .LSB_FIRST(1), .SIZE_W(SW), .MAX_BYTES(CAP0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0), .bus(b0.slave),
        .image_size(isz0), .done(done0), .overflow(ovf0));
    jaxis_byte_packer #(.IN_BYTES(IB), .OUT_BYTES(OB), .LSB_FIRST(0), .SIZE_W(SW), .MAX_BYTES(CAP1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1), .bus(b1.slave),
        .image_size(isz1), .done(done1), .overflow(ovf1));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required finish within 50000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input int d, input logic v, input logic [8*IB-1:0] dat, input logic [2:0] nb, input logic tl);
        if (d == 0) begin b0.in_valid = v; b0.in_data = dat; b0.in_nbytes = nb; b0.in_tlast = tl; end
        else        begin b1.in_valid = v; b1.in_data = dat; b1.in_nbytes = nb; b1.in_tlast = tl; end
    endtask

    function automatic logic get_hold(input int d);  return (d == 0) ? b0.in_hold : b1.in_hold; endfunction
    function automatic logic get_done(input int d);  return (d == 0) ? done0 : done1;           endfunction
    function automatic logic get_ovf(input int d);   return (d == 0) ? ovf0 : ovf1;             endfunction
    function automatic logic [SW-1:0] get_isz(input int d); return (d == 0) ? isz0 : isz1;     endfunction

    // Reference: the image is the ordered byte stream, truncated at the cap, cut into OB-byte words.
    task automatic model(input int d, input int nbs[$], output int kept, output bit ovf);
        int total, cap;
        bit lsb;
        word_t x;
        cap = (d == 0) ? CAP0 : CAP1;
        lsb = (d == 0);
        total = 0;
        foreach (nbs[i]) total += (nbs[i] > IB) ? IB : nbs[i];
        kept = (total < cap) ? total : cap;
        ovf  = (total > cap);
        if (kept == 0) begin
            x.data = '0; x.keep = '0; x.last = 1'b1;
            if (d == 0) q0.push_back(x); else q1.push_back(x);
        end
        for (int w = 0; w * OB < kept; w++) begin
            x.data = '0; x.keep = '0;
            for (int b = 0; b < OB; b++) begin
                int idx, pos;
                idx = w * OB + b;
                pos = lsb ? b : OB - 1 - b;
                if (idx < kept) begin
                    x.data[8*pos +: 8] = idx[7:0];
                    x.keep[pos] = 1'b1;
                end
            end
            x.last = ((w + 1) * OB >= kept);
            if (d == 0) q0.push_back(x); else q1.push_back(x);
        end
    endtask

    task automatic drive_beats(input int d, input int nbs[$], input bit tl, input int gap_pct);
        int idx, eff, waited;
        logic [8*IB-1:0] dat;
        idx = 0;
        foreach (nbs[i]) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                set_in(d, 1'b0, '0, 3'd0, 1'b0);
                @(posedge clk); #1;
            end
            eff = (nbs[i] > IB) ? IB : nbs[i];
            dat = $urandom;
            for (int k = 0; k < eff; k++) dat[8*k +: 8] = 8'(idx + k);
            idx += eff;
            set_in(d, 1'b1, dat, 3'(nbs[i]), tl && (i == nbs.size() - 1));
            waited = 0;
            forever begin
                @(negedge clk);
                if (!get_hold(d)) break;
                waited++;
                if (waited > 3000) begin
                    tests++; fails++;
                    $display("FAIL accept_timeout dut%0d: got in_hold=1 for %0d cycles, required beat accepted", d, waited);
                    break;
                end
            end
            @(posedge clk); #1;
        end
        set_in(d, 1'b0, '0, 3'd0, 1'b0);
    endtask

    task automatic pulse_start(input int d);
        if (d == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
    endtask

    task automatic run_image(input int d, input int nbs[$], input int gap_pct);
        int kept, cyc;
        bit ovf;
        pulse_start(d);
        chk($sformatf("start_size_clr dut%0d", d), 64'(get_isz(d)), 64'd0);
        chk($sformatf("start_ovf_clr dut%0d", d), 64'(get_ovf(d)), 64'd0);
        chk($sformatf("start_done_clr dut%0d", d), 64'(get_done(d)), 64'd0);
        model(d, nbs, kept, ovf);
        drive_beats(d, nbs, 1'b1, gap_pct);
        cyc = 0;
        while (!get_done(d) && cyc < 3000) begin @(posedge clk); #1; cyc++; end
        chk($sformatf("done dut%0d", d), 64'(get_done(d)), 64'd1);
        chk($sformatf("image_size dut%0d", d), 64'(get_isz(d)), 64'(kept));
        chk($sformatf("overflow dut%0d", d), 64'(get_ovf(d)), 64'(ovf));
        chk($sformatf("words_left dut%0d", d), 64'((d == 0) ? q0.size() : q1.size()), 64'd0);
        chk($sformatf("hold_in_done dut%0d", d), 64'(get_hold(d)), 64'd1);
    endtask

    task automatic rand_beats(input int total, output int nbs[$]);
        int r, nb;
        r = total;
        nbs = {};
        while (r > 0) begin
            nb = $urandom_range(0, 7);
            if (((nb > IB) ? IB : nb) > r) nb = r;
            r -= (nb > IB) ? IB : nb;
            nbs.push_back(nb);
        end
    endtask

    task automatic mon(input int d);
        logic v, r, ab;
        logic [8*OB+OB:0] w;
        word_t e;
        v  = (d == 0) ? b0.m_tvalid : b1.m_tvalid;
        r  = (d == 0) ? b0.m_tready : b1.m_tready;
        ab = (d == 0) ? abort0 : abort1;
        w  = (d == 0) ? {b0.m_tlast, b0.m_tkeep, b0.m_tdata} : {b1.m_tlast, b1.m_tkeep, b1.m_tdata};
        if (prev_stall[d]) begin
            tests++;
            if (!v || w !== prev_w[d]) begin
                fails++;
                $display("FAIL stall_hold dut%0d: got valid=%b word=%h, required valid=1 word=%h", d, v, w, prev_w[d]);
            end
        end
        prev_stall[d] = v && !r && !ab;
        prev_w[d] = w;
        if (v && r) begin
            tests++;
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                fails++;
                $display("FAIL extra_word dut%0d: got {last,keep,data}=%h, required no word", d, w);
            end else begin
                if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                if (w !== {e.last, e.keep, e.data}) begin
                    fails++;
                    $display("FAIL out_word dut%0d: got {last,keep,data}=%h, required %h", d, w, {e.last, e.keep, e.data});
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon(0);
            mon(1);
            if (b0.in_valid && b0.in_hold) hold_seen++;
        end
    end

    initial begin
        b0.m_tready = 1'b0;
        b1.m_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            b0.m_tready = ($urandom_range(0, 99) < rdy_pct[0]);
            b1.m_tready = ($urandom_range(0, 99) < rdy_pct[1]);
        end
    end

    initial begin
        int nb[$];
        set_in(0, 1'b0, '0, 3'd0, 1'b0);
        set_in(1, 1'b0, '0, 3'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold", 64'(b0.in_hold), 64'd1);
        chk("rst_tvalid", 64'(b0.m_tvalid), 64'd0);
        chk("rst_tlast", 64'(b0.m_tlast), 64'd0);
        chk("rst_tdata", 64'(b0.m_tdata), 64'd0);
        chk("rst_tkeep", 64'(b0.m_tkeep), 64'd0);
        chk("rst_size", 64'(isz0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_ovf", 64'(ovf0), 64'd0);
        chk("rst_tvalid1", 64'(b1.m_tvalid), 64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_hold", 64'(b0.in_hold), 64'd1);

        nb = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
        run_image(0, nb, 0);
        nb = '{3, 1, 2, 1};
        run_image(0, nb, 0);
        nb = '{0};
        run_image(0, nb, 0);

        rdy_pct[0] = 30;
        hold_seen = 0;
        rand_beats(64, nb);
        run_image(0, nb, 15);
        chk("hold_when_full", 64'(hold_seen > 0), 64'd1);
        rdy_pct[0] = 60;
        rand_beats(37, nb);
        run_image(0, nb, 25);

        // abort with words stuck behind a stalled sink
        rdy_pct[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        pulse_start(1);
        nb = '{4, 4};
        drive_beats(1, nb, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_pre_valid", 64'(b1.m_tvalid), 64'd1);
        abort1 = 1'b1;
        @(posedge clk); #1;
        abort1 = 1'b0;
        chk("abort_tvalid", 64'(b1.m_tvalid), 64'd0);
        chk("abort_hold", 64'(b1.in_hold), 64'd1);
        chk("abort_done", 64'(done1), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_tvalid_late", 64'(b1.m_tvalid), 64'd0);
        rdy_pct[1] = 100;
        repeat (2) @(posedge clk);
        #1;

        nb = '{3, 1, 2, 1};
        run_image(1, nb, 0);
        nb = '{4, 4, 4, 4, 4, 4};
        run_image(1, nb, 0);
        rdy_pct[1] = 30;
        rand_beats(12, nb);
        run_image(1, nb, 10);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
